// File: rtl/synth_pkg.sv
// Shared types for the synth voice/operator sequencer: slot id, register-write
// scope encoding, the queued write record and the host address-field layout.
package synth_pkg;

  // Host register number layout: {scope[1:0], param[5:0], index[7:0]}
  localparam int REG_NUM_W = 16;
  localparam int SCOPE_HI  = 15;
  localparam int SCOPE_LO  = 14;
  localparam int PARAM_HI  = 13;
  localparam int PARAM_LO  = 8;
  localparam int INDEX_HI  = 7;
  localparam int INDEX_LO  = 0;

  // Widest slot id (32 voices x 8 operators)
  localparam int MAX_SLOT_W = 8;

  typedef logic [MAX_SLOT_W-1:0] VoiceOperatorID_t;

  typedef enum logic [1:0] {
    SCOPE_RESERVED = 2'b00,
    SCOPE_GLOBAL   = 2'b01,
    SCOPE_VOICE    = 2'b10,
    SCOPE_VOICE_OP = 2'b11
  } RegScope_t;

  typedef struct packed {
    RegScope_t   scope;
    logic [5:0]  param;
    logic [7:0]  index;
    logic [7:0]  data;
  } RegWrite_t;

  // Split a host register number and value into a queued write record
  function automatic RegWrite_t unpack_write(input logic [REG_NUM_W-1:0] num,
                                             input logic [7:0] val);
    RegWrite_t w;
    w.scope = RegScope_t'(num[SCOPE_HI:SCOPE_LO]);
    w.param = num[PARAM_HI:PARAM_LO];
    w.index = num[INDEX_HI:INDEX_LO];
    w.data  = val;
    return w;
  endfunction

endpackage

// File: rtl/reg_write_fifo.sv
// Synchronous FIFO of RegWrite_t records. Head is visible combinationally
// so the issue logic can inspect and pop it in the same cycle.
module reg_write_fifo
  import synth_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      i_Clock,
  input  logic      i_Reset_n,
  input  logic      i_Push,
  input  RegWrite_t i_Data,
  input  logic      i_Pop,
  output RegWrite_t o_Head,
  output logic      o_Full,
  output logic      o_Empty
);

  localparam int AW = $clog2(DEPTH);

  RegWrite_t       r_Mem [DEPTH];
  logic [AW-1:0]   r_Wr;
  logic [AW-1:0]   r_Rd;
  logic [AW:0]     r_Count;
  logic            w_DoPush;
  logic            w_DoPop;

  assign o_Full   = (r_Count == (AW+1)'(DEPTH));
  assign o_Empty  = (r_Count == '0);
  assign w_DoPush = i_Push && !o_Full;
  assign w_DoPop  = i_Pop && !o_Empty;
  assign o_Head   = r_Mem[r_Rd];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge i_Clock) begin
    if (w_DoPush) r_Mem[r_Wr] <= i_Data;
  end

  // Pointers and occupancy; reset flushes everything in flight
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Wr    <= '0;
      r_Rd    <= '0;
      r_Count <= '0;
    end else begin
      if (w_DoPush) r_Wr <= r_Wr + 1'b1;
      if (w_DoPop)  r_Rd <= r_Rd + 1'b1;
      case ({w_DoPush, w_DoPop})
        2'b10:   r_Count <= r_Count + 1'b1;
        2'b01:   r_Count <= r_Count - 1'b1;
        default: r_Count <= r_Count;
      endcase
    end
  end

endmodule

// File: rtl/voice_op_sequencer.sv
// Voice-operator slot sequencer with frame markers and an in-order register
// write issue path. Build macro SYNTH_WRITE_HAZARD_EN enables holding
// voice-op writes whose target slot is still inside the pipeline.
module voice_op_sequencer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES     = 32,
  parameter int NUM_OPERATORS  = 8,
  parameter int PIPELINE_DEPTH = 4,
  parameter int FIFO_DEPTH     = 8,
  localparam int N             = NUM_VOICES * NUM_OPERATORS,
  localparam int SLOT_W        = $clog2(N)
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_RegisterWriteEnable,
  output logic                 o_RegisterWriteReady,
  input  logic [REG_NUM_W-1:0] i_RegisterWriteNumber,
  input  logic [7:0]           i_RegisterWriteValue,
  output logic [SLOT_W-1:0]    o_VoiceOperator,
  output logic                 o_FrameStart,
  output logic                 o_FrameEnd,
  output logic                 o_CfgWriteEnable,
  output logic [1:0]           o_CfgWriteScope,
  output logic [5:0]           o_CfgWriteParam,
  output logic [7:0]           o_CfgWriteIndex,
  output logic [7:0]           o_CfgWriteData,
  output logic                 o_WriteError
);

  // Elaboration-time parameter sanity
  if (NUM_VOICES < 2 || NUM_VOICES > 32 || (NUM_VOICES & (NUM_VOICES-1)) != 0) begin : g_bad_voices
    $error("NUM_VOICES must be a power of two in 2..32");
  end
  if (NUM_OPERATORS < 2 || NUM_OPERATORS > 8 || (NUM_OPERATORS & (NUM_OPERATORS-1)) != 0) begin : g_bad_ops
    $error("NUM_OPERATORS must be a power of two in 2..8");
  end
  if (PIPELINE_DEPTH < 1 || PIPELINE_DEPTH > N-1) begin : g_bad_depth
    $error("PIPELINE_DEPTH must be in 1..N-1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [SLOT_W-1:0] r_Slot;
  logic              r_Running;
  RegWrite_t         w_In;
  RegWrite_t         w_Head;
  logic              w_Full;
  logic              w_Empty;
  logic              w_Hold;
  logic              w_Pop;

  // Slot counter: idle at 0 in reset, arm on the first edge, then free-run.
  // N is a power of two, so natural SLOT_W-bit wrap gives the modulo.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Slot    <= '0;
      r_Running <= 1'b0;
    end else if (!r_Running) begin
      r_Running <= 1'b1;
    end else begin
      r_Slot <= r_Slot + 1'b1;
    end
  end

  assign o_VoiceOperator = r_Slot;
  assign o_FrameStart    = r_Running && (r_Slot == '0);
  assign o_FrameEnd      = r_Running && (r_Slot == SLOT_W'(N-1));

  assign w_In                 = unpack_write(i_RegisterWriteNumber, i_RegisterWriteValue);
  assign o_RegisterWriteReady = !w_Full;

  reg_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Push    (i_RegisterWriteEnable),
    .i_Data    (w_In),
    .i_Pop     (w_Pop),
    .o_Head    (w_Head),
    .o_Full    (w_Full),
    .o_Empty   (w_Empty)
  );

`ifdef SYNTH_WRITE_HAZARD_EN
  logic [SLOT_W-1:0] w_Dist;

  // Hold a voice-op write whose slot is within the next PIPELINE_DEPTH
  // positions ahead of the counter (i.e. still being computed downstream)
  always_comb begin
    w_Dist = w_Head.index[SLOT_W-1:0] - r_Slot;
    w_Hold = (w_Head.scope == SCOPE_VOICE_OP) && (w_Dist < SLOT_W'(PIPELINE_DEPTH));
  end
`else
  assign w_Hold = 1'b0;
`endif

  assign w_Pop = !w_Empty && !w_Hold;

  // Issue register: one strobe per popped entry, reserved scope flagged
  // as an error; cfg fields hold their last issued values otherwise
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_CfgWriteEnable <= 1'b0;
      o_CfgWriteScope  <= '0;
      o_CfgWriteParam  <= '0;
      o_CfgWriteIndex  <= '0;
      o_CfgWriteData   <= '0;
      o_WriteError     <= 1'b0;
    end else begin
      o_CfgWriteEnable <= 1'b0;
      o_WriteError     <= 1'b0;
      if (w_Pop) begin
        if (w_Head.scope == SCOPE_RESERVED) begin
          o_WriteError <= 1'b1;
        end else begin
          o_CfgWriteEnable <= 1'b1;
          o_CfgWriteScope  <= w_Head.scope;
          o_CfgWriteParam  <= w_Head.param;
          o_CfgWriteIndex  <= w_Head.index;
          o_CfgWriteData   <= w_Head.data;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_op_sequencer.sv
// Directed bench for voice_op_sequencer at default parameters. Follows
// SYNTH_WRITE_HAZARD_EN so expectations match the build being simulated.
module tb_voice_op_sequencer;

`ifdef SYNTH_WRITE_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wnum = '0;
  logic [7:0]  wval = '0;
  logic        ready;
  logic [7:0]  slot;
  logic        fs, fe, en, err;
  logic [1:0]  scope;
  logic [5:0]  param;
  logic [7:0]  index, data;

  int checks = 0;
  int errors = 0;

  voice_op_sequencer dut (
    .i_Clock               (clk),
    .i_Reset_n             (rst_n),
    .i_RegisterWriteEnable (we),
    .o_RegisterWriteReady  (ready),
    .i_RegisterWriteNumber (wnum),
    .i_RegisterWriteValue  (wval),
    .o_VoiceOperator       (slot),
    .o_FrameStart          (fs),
    .o_FrameEnd            (fe),
    .o_CfgWriteEnable      (en),
    .o_CfgWriteScope       (scope),
    .o_CfgWriteParam       (param),
    .o_CfgWriteIndex       (index),
    .o_CfgWriteData        (data),
    .o_WriteError          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] n, input logic [7:0] v);
    we = 1'b1; wnum = n; wval = v;
    tick();
    we = 1'b0;
  endtask

  task automatic wait_slot(input int s);
    bit hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      tick();
      if (slot == 8'(s)) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL wait_slot got %0d want %0d", slot, s); end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({slot, fs, fe, en, scope, param, index, data, err, ready} !== {8'd0, 3'b000, 2'd0, 6'd0, 8'd0, 8'd0, 2'b01}) begin
      errors++;
      $display("FAIL reset_vals got slot=%0d fs=%b fe=%b en=%b err=%b rdy=%b want zeros rdy=1", slot, fs, fe, en, err, ready);
    end
    tick(); tick();
    checks++;
    if ({slot, fs, fe, en, ready} !== {8'd0, 3'b000, 1'b1}) begin
      errors++; $display("FAIL reset_hold got slot=%0d fs=%b fe=%b en=%b rdy=%b want 0 0 0 0 1", slot, fs, fe, en, ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_slot_counter();
    int fe_cnt = 0;
    int first_fe = -1;
    logic [7:0] exp_slot;
    for (int c = 1; c <= 600; c++) begin
      tick();
      exp_slot = 8'((c - 1) % 256);
      if (fe) begin fe_cnt++; if (first_fe < 0) first_fe = c; end
      checks++;
      if ({slot, fs, fe} !== {exp_slot, exp_slot == 8'd0, exp_slot == 8'd255}) begin
        errors++;
        $display("FAIL slot_seq c=%0d got slot=%0d fs=%b fe=%b want slot=%0d", c, slot, fs, fe, exp_slot);
      end
    end
    checks++;
    if (fe_cnt !== 2) begin errors++; $display("FAIL frame_end_count got %0d want 2", fe_cnt); end
    checks++;
    if (first_fe !== 256) begin errors++; $display("FAIL first_frame_end got %0d want 256", first_fe); end
  endtask

  task automatic test_single_write();
    wait_slot(10);
    push(16'hC105, 8'hAB);
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL single_early got en=%b want 0", en); end
    tick();
    checks++;
    if ({en, scope, param, index, data} !== {1'b1, 2'b11, 6'h01, 8'h05, 8'hAB}) begin
      errors++;
      $display("FAIL single_issue got en=%b sc=%0d p=%h i=%h d=%h want 1 3 01 05 ab", en, scope, param, index, data);
    end
    tick();
    checks++;
    if ({en, scope, param, index, data} !== {1'b0, 2'b11, 6'h01, 8'h05, 8'hAB}) begin
      errors++;
      $display("FAIL single_hold got en=%b sc=%0d p=%h i=%h d=%h want 0 3 01 05 ab", en, scope, param, index, data);
    end
  endtask

  task automatic test_hazard();
    int first = -1;
    int cnt = 0;
    wait_slot(10);
    push(16'hC20C, 8'h5A);
    for (int i = 0; i < 10; i++) begin
      if (en) begin
        cnt++;
        if (first < 0) begin
          first = i;
          checks++;
          if ({scope, param, index, data} !== {2'b11, 6'h02, 8'h0C, 8'h5A}) begin
            errors++;
            $display("FAIL hazard_fields got sc=%0d p=%h i=%h d=%h want 3 02 0c 5a", scope, param, index, data);
          end
        end
      end
      tick();
    end
    checks++;
    if (first !== (HAZ ? 3 : 1)) begin errors++; $display("FAIL hazard_delay got %0d want %0d", first, HAZ ? 3 : 1); end
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL hazard_count got %0d want 1", cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    int i = 0;
    int acc_before = -1;
    int refused = 0;
    int guard = 0;
    logic rdy;
    wait_slot(20);
    fork
      begin
        while (i < 10 && guard < 40) begin
          we = 1'b1; wnum = {2'b11, 6'h03, 8'(24 + 4 * i)}; wval = 8'(i);
          rdy = ready;
          tick();
          guard++;
          if (rdy) i++;
          else begin refused++; if (acc_before < 0) acc_before = i; end
        end
        we = 1'b0;
      end
      begin
        for (int c = 0; c < 70; c++) begin
          if (en) q.push_back({index, data});
          tick();
        end
      end
    join
    checks++;
    if (refused !== (HAZ ? 1 : 0)) begin errors++; $display("FAIL b2b_refused got %0d want %0d", refused, HAZ ? 1 : 0); end
    checks++;
    if (acc_before !== (HAZ ? 9 : -1)) begin errors++; $display("FAIL b2b_full_after got %0d want %0d", acc_before, HAZ ? 9 : -1); end
    checks++;
    if (q.size() !== 10) begin errors++; $display("FAIL b2b_issue_count got %0d want 10", q.size()); end
    for (int j = 0; j < 10 && j < q.size(); j++) begin
      checks++;
      if (q[j] !== {8'(24 + 4 * j), 8'(j)}) begin
        errors++; $display("FAIL b2b_order j=%0d got %h want %h", j, q[j], {8'(24 + 4 * j), 8'(j)});
      end
    end
  endtask

  task automatic test_write_error();
    push(16'h0500, 8'h00);
    push(16'h4000, 8'h01);
    checks++;
    if ({err, en} !== 2'b10) begin errors++; $display("FAIL err_pulse got err=%b en=%b want 1 0", err, en); end
    tick();
    checks++;
    if ({err, en, scope, param, index, data} !== {2'b01, 2'b01, 6'h00, 8'h00, 8'h01}) begin
      errors++;
      $display("FAIL err_next got err=%b en=%b sc=%0d p=%h i=%h d=%h want 0 1 1 00 00 01", err, en, scope, param, index, data);
    end
    tick();
    checks++;
    if ({err, en} !== 2'b00) begin errors++; $display("FAIL err_once got err=%b en=%b want 0 0", err, en); end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    wait_slot(40);
    push(16'hC32C, 8'h01);
    push(16'hC32C, 8'h02);
    push(16'hC32C, 8'h03);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({slot, fs, fe, en, scope, param, index, data, err, ready} !== {8'd0, 3'b000, 2'd0, 6'd0, 8'd0, 8'd0, 2'b01}) begin
      errors++;
      $display("FAIL midreset_vals got slot=%0d en=%b sc=%0d d=%h err=%b rdy=%b want zeros rdy=1", slot, en, scope, data, err, ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (en || err) strobes++;
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (en || err) strobes++;
      checks++;
      if ({slot, fs} !== {8'(c - 1), c == 1}) begin
        errors++; $display("FAIL midreset_restart c=%0d got slot=%0d fs=%b want %0d", c, slot, fs, c - 1);
      end
    end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL midreset_strobes got %0d want 0", strobes); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", ready); end
  endtask

  initial begin
    test_reset();
    test_slot_counter();
    test_single_write();
    test_hazard();
    test_back_to_back();
    test_write_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_op_sequencer.md
# voice_op_sequencer

Parametrised successor to the synth top-level slot counter and register-write decode. Generates the operator-major voice-operator slot sequence with frame markers, and accepts host register writes through a valid/ready port into a small FIFO. It decodes each write's scope, parameter and index fields and issues them in order to the pipeline stages. Writes to a voice operator whose slot is currently in flight are held back, so configuration never changes mid-computation.

## Interface
Parameters:
- NUM_VOICES, 32, voices per frame; power of two, 2..32
- NUM_OPERATORS, 8, operators per voice; power of two, 2..8
- PIPELINE_DEPTH, 4, number of slots in flight after the counter; 1..NUM_VOICES*NUM_OPERATORS-1
- FIFO_DEPTH, 8, register-write FIFO entries; power of two, ≥2

Ports:
- i_Clock  in  1  sole clock
- i_Reset_n  in  1  asynchronous, active-low reset
- i_RegisterWriteEnable  in  1  write valid
- o_RegisterWriteReady  out  1  FIFO not full
- i_RegisterWriteNumber  in  16  {scope[1:0], param[5:0], index[7:0]}
- i_RegisterWriteValue  in  8  write data
- o_VoiceOperator  out  SLOT_W  current slot = op*NUM_VOICES+voice; SLOT_W=clog2(NUM_VOICES*NUM_OPERATORS)
- o_FrameStart  out  1  current slot is 0 (running only)
- o_FrameEnd  out  1  current slot is last; this is the sample-ready strobe
- o_CfgWriteEnable  out  1  one-cycle issue strobe
- o_CfgWriteScope  out  2  11 voice-op, 10 voice, 01 global
- o_CfgWriteParam  out  6  parameter number
- o_CfgWriteIndex  out  8  index field, passed through unchanged
- o_CfgWriteData  out  8  data
- o_WriteError  out  1  one-cycle pulse when a scope-00 entry is discarded

## Operation
- Slot counter:
  - Held at 0 while reset is asserted.
  - r_Running is set at the first edge after reset release.
  - From then on, increments every cycle and wraps from NUM_VOICES*NUM_OPERATORS-1 to 0.
  - o_FrameStart = running && slot==0; o_FrameEnd = running && slot==last.
- Write port: an entry is pushed when enable && ready at a clock edge. There is no bypass; a write is refused while the FIFO is full.
- Issue logic:
  - Examines the FIFO head each cycle; strictly in order, at most one issue per cycle.
  - Scope 00: popped and discarded; o_WriteError pulses.
  - Scope 10/01: issued immediately.
  - Scope 11, hazard check: with idx = index[SLOT_W-1:0], the head is held while (idx - slot) mod N < PIPELINE_DEPTH, where slot is the current counter value and N = NUM_VOICES*NUM_OPERATORS. Unused upper index bits are ignored by the check.
- Maximum hazard stall is PIPELINE_DEPTH cycles, so there is no starvation. Head-of-line blocking is accepted.
- Issue outputs are registered. All cfg outputs hold their last values when o_CfgWriteEnable is low.

## Timing
- Reset values:
  - o_VoiceOperator, o_FrameStart, o_FrameEnd, all o_Cfg*, o_WriteError: 0.
  - o_RegisterWriteReady: 1 (FIFO empty).
- Push-to-issue latency: entry pushed at edge k into an empty FIFO, no hazard → o_CfgWriteEnable high for the cycle following edge k+1.
- Simultaneous push and pop: FIFO count is unchanged; ready stays as is.
- Full FIFO: ready deasserts in the cycle after the edge that fills it and reasserts the cycle after a pop.
- Reset mid-operation: the FIFO is flushed and in-flight entries are lost. No strobe is asserted while reset is low.
- o_FrameEnd recurs every N cycles; the first one occurs N cycles after reset release.

## Configuration
- SYNTH_WRITE_HAZARD_EN:
  - Defined: the scope-11 in-flight hold described above is active.
  - Undefined: the hazard check is compiled out and the head issues every cycle whenever the FIFO is non-empty. Scope-00 discard is unchanged.

## Structure
- synth_pkg holds:
  - VoiceOperatorID_t
  - RegScope_t enum (SCOPE_RESERVED, SCOPE_GLOBAL, SCOPE_VOICE, SCOPE_VOICE_OP)
  - RegWrite_t packed struct {scope, param, index, data}
  - the address-field bit positions
- One sub-module: reg_write_fifo. It is a synchronous FIFO of RegWrite_t, parametrised by depth, with async active-low reset and push/pop/full/empty.
- Slot counter, hazard compare and issue register live in voice_op_sequencer.

## Test plan
- Defaults; release reset, run 600 cycles → o_VoiceOperator 0,1,…,255,0; o_FrameEnd high exactly at slot 255, every 256 cycles; o_FrameStart at slot 0.
- Write 0xC1_05/0xAB while slot=10 → strobe one cycle later with scope 11, param 0x01, index 0x05, data 0xAB.
- Macro on, PIPELINE_DEPTH=4; write voice-op index 0x0C while slot=10 → held until slot=13 → issued once, unchanged. Macro off → issued immediately.
- Push 9 writes back-to-back with a hazard held at the head → ready low after the 8th push; all 8 accepted entries issue in order; the 9th is accepted after the first pop.
- Write scope 00 (0x05_00) → o_WriteError pulses once, no o_CfgWriteEnable; the following global write 0x40_00/0x01 issues the next cycle.
- Assert i_Reset_n low for 3 cycles with 3 FIFO entries queued → outputs 0 immediately, ready=1, no strobes after release, slot restarts at 0.
